// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: three-stage quadrant-decomposed approximate multiplier.
// Operands are split into four half-width quarter products; each quarter can
// have its low T bits truncated, and the quarters are merged either by exact
// addition or by bitwise OR. A single global stall freezes every stage while
// a result waits on out_ready.
module approx_mult_pipe #(
   parameter int N     = 8,
   parameter int T     = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic [4:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   out_p,
   output logic [CNT_W-1:0] done_cnt
);

   localparam int H = N / 2;
   // Bits of a quarter product that are cleared when it is approximated.
   localparam logic [N-1:0] LOW_MASK = ~({N{1'b1}} << T);

   // Exact H x H product, widened before multiplying so no bits are lost.
   function automatic logic [N-1:0] qmul(input logic [H-1:0] x, input logic [H-1:0] y);
      logic [N-1:0] xe;
      logic [N-1:0] ye;
      xe = N'(x);
      ye = N'(y);
      return xe * ye;
   endfunction

   // Optional low-bit truncation of one quarter product.
   function automatic logic [N-1:0] trunc_q(input logic [N-1:0] q, input logic en);
      return en ? (q & ~LOW_MASK) : q;
   endfunction

   // Merge the four quarters at full 2N width, by addition or by OR.
   function automatic logic [2*N-1:0] combine(input logic [N-1:0] ll, input logic [N-1:0] lh,
                                              input logic [N-1:0] hl, input logic [N-1:0] hh,
                                              input logic use_or);
      logic [2*N-1:0] e_ll;
      logic [2*N-1:0] e_lh;
      logic [2*N-1:0] e_hl;
      logic [2*N-1:0] e_hh;
      e_ll = {{N{1'b0}}, ll};
      e_lh = {{N{1'b0}}, lh} << H;
      e_hl = {{N{1'b0}}, hl} << H;
      e_hh = {{N{1'b0}}, hh} << N;
      if (use_or) return e_ll | e_lh | e_hl | e_hh;
      else        return e_ll + e_lh + e_hl + e_hh;
   endfunction

   logic             stall;
   logic             advance;

   logic             vld_p1_q, vld_p2_q, vld_p3_q;
   logic [N-1:0]     a_p1_q, b_p1_q;
   logic [4:0]       mode_p1_q;
   logic [N-1:0]     ll_p2_q, lh_p2_q, hl_p2_q, hh_p2_q;
   logic             or_p2_q;
   logic [2*N-1:0]   p_p3_q;
   logic [CNT_W-1:0] cnt_q;

   logic [N-1:0]     ll_d, lh_d, hl_d, hh_d;
   logic [2*N-1:0]   p_d;
   logic [CNT_W-1:0] cnt_d;

   assign stall     = vld_p3_q & ~out_ready;
   assign advance   = ~stall;
   assign in_ready  = ~stall;
   assign out_valid = vld_p3_q;
   assign out_p     = p_p3_q;
   assign done_cnt  = cnt_q;

   // Next-state values: quarter products from S1, combined product from S2, counter.
   always_comb begin
      ll_d  = trunc_q(qmul(a_p1_q[H-1:0], b_p1_q[H-1:0]), mode_p1_q[0]);
      lh_d  = trunc_q(qmul(a_p1_q[H-1:0], b_p1_q[N-1:H]), mode_p1_q[1]);
      hl_d  = trunc_q(qmul(a_p1_q[N-1:H], b_p1_q[H-1:0]), mode_p1_q[2]);
      hh_d  = trunc_q(qmul(a_p1_q[N-1:H], b_p1_q[N-1:H]), mode_p1_q[3]);
      p_d   = combine(ll_p2_q, lh_p2_q, hl_p2_q, hh_p2_q, or_p2_q);
      cnt_d = cnt_q;
      if (vld_p3_q && out_ready) cnt_d = cnt_q + CNT_W'(1);
   end

   // Valid bits: a word enters S1 only when accepted, all stages freeze on stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
      end else if (advance) begin
         vld_p1_q <= in_valid;
         vld_p2_q <= vld_p1_q;
         vld_p3_q <= vld_p2_q;
      end
   end

   // S1/S2 data registers: operands, then quarter products; held during stall.
   always_ff @(posedge clk) begin
      if (advance) begin
         a_p1_q    <= in_a;
         b_p1_q    <= in_b;
         mode_p1_q <= in_mode;
         ll_p2_q   <= ll_d;
         lh_p2_q   <= lh_d;
         hl_p2_q   <= hl_d;
         hh_p2_q   <= hh_d;
         or_p2_q   <= mode_p1_q[4];
      end
   end

   // S3 product register: cleared on reset, loads only real results.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_p3_q <= '0;
      end else if (advance && vld_p2_q) begin
         p_p3_q <= p_d;
      end
   end

   // Delivered-result counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Testbench for approx_mult_pipe: directed vectors, a mode sweep, backpressure,
// mid-stream reset, and a parameter sweep over several instances.
module tb_approx_mult_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a, in_b;
   logic [4:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_p;
   logic [15:0] done_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   approx_mult_pipe #(.N(8), .T(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_p(out_p), .done_cnt(done_cnt));

   // Auxiliary instances sharing one stimulus bus, always ready downstream.
   logic        aux_valid;
   logic [15:0] aux_a, aux_b;
   logic [4:0]  aux_mode;
   logic        u4_ir, u12_ir, u16a_ir, u16b_ir;
   logic        u4_ov, u12_ov, u16a_ov, u16b_ov;
   logic [7:0]  u4_p;
   logic [23:0] u12_p;
   logic [31:0] u16a_p, u16b_p;
   logic [3:0]  u4_cnt;
   logic [15:0] u12_cnt, u16a_cnt, u16b_cnt;

   approx_mult_pipe #(.N(4), .T(0), .CNT_W(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(aux_valid), .in_ready(u4_ir),
      .in_a(aux_a[3:0]), .in_b(aux_b[3:0]), .in_mode(aux_mode), .out_valid(u4_ov),
      .out_ready(1'b1), .out_p(u4_p), .done_cnt(u4_cnt));
   approx_mult_pipe #(.N(12), .T(0), .CNT_W(16)) u12 (
      .clk(clk), .rst(rst), .in_valid(aux_valid), .in_ready(u12_ir),
      .in_a(aux_a[11:0]), .in_b(aux_b[11:0]), .in_mode(aux_mode), .out_valid(u12_ov),
      .out_ready(1'b1), .out_p(u12_p), .done_cnt(u12_cnt));
   approx_mult_pipe #(.N(16), .T(0), .CNT_W(16)) u16a (
      .clk(clk), .rst(rst), .in_valid(aux_valid), .in_ready(u16a_ir),
      .in_a(aux_a), .in_b(aux_b), .in_mode(aux_mode), .out_valid(u16a_ov),
      .out_ready(1'b1), .out_p(u16a_p), .done_cnt(u16a_cnt));
   approx_mult_pipe #(.N(16), .T(8), .CNT_W(16)) u16b (
      .clk(clk), .rst(rst), .in_valid(aux_valid), .in_ready(u16b_ir),
      .in_a(aux_a), .in_b(aux_b), .in_mode(aux_mode), .out_valid(u16b_ov),
      .out_ready(1'b1), .out_p(u16b_p), .done_cnt(u16b_cnt));

   // Reference: quarter products built from masks and shifts on 64-bit integers.
   function automatic longint ref_p(input int n, input int t, input longint a, input longint b,
                                    input logic [4:0] mode);
      int     h;
      longint m;
      longint q[4];
      longint sh[4];
      longint r;
      h = n / 2;
      m = (64'd1 << h) - 1;
      q[0] = (a & m) * (b & m);
      q[1] = (a & m) * ((b >> h) & m);
      q[2] = ((a >> h) & m) * (b & m);
      q[3] = ((a >> h) & m) * ((b >> h) & m);
      sh[0] = 0; sh[1] = h; sh[2] = h; sh[3] = n;
      r = 0;
      for (int i = 0; i < 4; i++) begin
         if (mode[i]) q[i] = q[i] & ~((64'd1 << t) - 1);
         if (mode[4]) r = r | (q[i] << sh[i]);
         else         r = r + (q[i] << sh[i]);
      end
      return r;
   endfunction

   // One transaction on the main instance; returns product, edges to result, counts.
   task automatic xact(input logic [7:0] a, input logic [7:0] b, input logic [4:0] mode,
                       output logic [15:0] p, output int lat,
                       output logic [15:0] cnt_before, output logic [15:0] cnt_after);
      @(negedge clk);
      cnt_before = done_cnt;
      in_a = a; in_b = b; in_mode = mode; in_valid = 1'b1; out_ready = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 10);
      p = out_p;
      @(negedge clk);
      cnt_after = done_cnt;
   endtask

   // Drive one word on the aux bus and wait until the aux results are valid.
   task automatic aux_xact(input logic [15:0] a, input logic [15:0] b, input logic [4:0] mode,
                           output int lat);
      @(negedge clk);
      aux_a = a; aux_b = b; aux_mode = mode; aux_valid = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         aux_valid = 1'b0;
         lat++;
      end while (!u4_ov && lat < 10);
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; aux_valid = 1'b0;
      in_a = '0; in_b = '0; in_mode = '0; aux_a = '0; aux_b = '0; aux_mode = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++; if (out_p !== 16'h0) begin failures++; $display("FAIL reset_out_p got=%h want=0000", out_p); end
      checks++; if (done_cnt !== 16'd0) begin failures++; $display("FAIL reset_done_cnt got=%0d want=0", done_cnt); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_exact;
      logic [15:0] p, c0, c1;
      int lat;
      xact(8'h03, 8'h05, 5'h00, p, lat, c0, c1);
      checks++; if (p !== 16'h000F) begin failures++; $display("FAIL exact_3x5 got=%h want=000F", p); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL exact_latency got=%0d want=3", lat); end
      checks++; if (c1 !== 16'd1) begin failures++; $display("FAIL exact_done_cnt got=%0d want=1", c1); end
      xact(8'hFF, 8'hFF, 5'h00, p, lat, c0, c1);
      checks++; if (p !== 16'hFE01) begin failures++; $display("FAIL exact_fullscale got=%h want=FE01", p); end
      checks++; if (c1 !== c0 + 16'd1) begin failures++; $display("FAIL exact_cnt_step got=%0d want=%0d", c1, c0 + 16'd1); end
   endtask

   task automatic test_approx;
      logic [15:0] p, c0, c1;
      int lat;
      xact(8'hFF, 8'hFF, 5'h0F, p, lat, c0, c1);
      checks++; if (p !== 16'hFCE0) begin failures++; $display("FAIL approx_all_add got=%h want=FCE0", p); end
      xact(8'h37, 8'h5B, 5'h01, p, lat, c0, c1);
      checks++; if (p !== 16'h138C) begin failures++; $display("FAIL approx_ll_only got=%h want=138C", p); end
   endtask

   task automatic test_or_combine;
      logic [15:0] p, c0, c1, exp;
      logic [7:0]  a, b;
      int lat;
      xact(8'hFF, 8'hFF, 5'h10, p, lat, c0, c1);
      checks++; if (p !== 16'hEFF1) begin failures++; $display("FAIL or_fullscale got=%h want=EFF1", p); end
      for (int m = 0; m < 32; m++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         exp = 16'(ref_p(8, 2, longint'(a), longint'(b), 5'(m)));
         xact(a, b, 5'(m), p, lat, c0, c1);
         checks++;
         if (p !== exp) begin
            failures++;
            $display("FAIL mode_sweep m=%0d a=%h b=%h got=%h want=%h", m, a, b, p, exp);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] expq[$];
      logic [15:0] exp, prev_p;
      logic [7:0]  wa, wb;
      logic [4:0]  wm;
      logic        was_stalled;
      int sent, got, cyc;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sent = 0; got = 0; cyc = 0; was_stalled = 1'b0; prev_p = '0;
      while (got < 10 && cyc < 200) begin
         @(negedge clk);
         out_ready = (cyc % 3 == 2);
         wa = 8'(sent * 23 + 1);
         wb = 8'(200 - sent * 7);
         wm = 5'(sent * 3);
         in_valid = (sent < 10);
         in_a = wa; in_b = wb; in_mode = wm;
         #1;
         checks++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            failures++;
            $display("FAIL b2b_in_ready cyc=%0d got=%b ov=%b or=%b", cyc, in_ready, out_valid, out_ready);
         end
         if (was_stalled) begin
            checks++;
            if (out_p !== prev_p) begin failures++; $display("FAIL b2b_stable cyc=%0d got=%h want=%h", cyc, out_p, prev_p); end
         end
         if (out_valid && out_ready) begin
            exp = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
            checks++;
            if (out_p !== exp) begin failures++; $display("FAIL b2b_order idx=%0d got=%h want=%h", got, out_p, exp); end
            got++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(16'(ref_p(8, 2, longint'(wa), longint'(wb), wm)));
            sent++;
         end
         was_stalled = out_valid && !out_ready;
         prev_p = out_p;
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (got !== 10) begin failures++; $display("FAIL b2b_count got=%0d want=10", got); end
      @(negedge clk);
      checks++; if (done_cnt !== 16'd10) begin failures++; $display("FAIL b2b_done_cnt got=%0d want=10", done_cnt); end
   endtask

   task automatic test_reset_midstream;
      int stale;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_a = 8'(i + 9); in_b = 8'(i + 4); in_mode = 5'h00;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_full_ov got=%b want=1", out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_stall_ir got=%b want=0", in_ready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_ov got=%b want=0", out_valid); end
      checks++; if (out_p !== 16'h0) begin failures++; $display("FAIL mid_rst_p got=%h want=0000", out_p); end
      checks++; if (done_cnt !== 16'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d want=0", done_cnt); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ir got=%b want=1", in_ready); end
      out_ready = 1'b1;
      stale = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stale++;
      end
      checks++; if (stale !== 0) begin failures++; $display("FAIL mid_no_stale got=%0d want=0", stale); end
   endtask

   task automatic test_param_sweep;
      logic [15:0] a, b;
      logic [7:0]  e4;
      logic [23:0] e12;
      logic [31:0] e16;
      int lat;
      for (int i = 0; i < 17; i++) begin
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 65535));
         aux_xact(a, b, 5'h00, lat);
         e4  = 8'(ref_p(4, 0, longint'(a[3:0]), longint'(b[3:0]), 5'h00));
         e12 = 24'(ref_p(12, 0, longint'(a[11:0]), longint'(b[11:0]), 5'h00));
         e16 = 32'(ref_p(16, 0, longint'(a), longint'(b), 5'h00));
         checks++; if (u4_p !== e4) begin failures++; $display("FAIL n4_exact a=%h b=%h got=%h want=%h", a[3:0], b[3:0], u4_p, e4); end
         checks++; if (u12_p !== e12) begin failures++; $display("FAIL n12_exact a=%h b=%h got=%h want=%h", a[11:0], b[11:0], u12_p, e12); end
         checks++; if (u16a_p !== e16) begin failures++; $display("FAIL n16_exact a=%h b=%h got=%h want=%h", a, b, u16a_p, e16); end
      end
      @(negedge clk);
      checks++; if (u4_cnt !== 4'd1) begin failures++; $display("FAIL cnt_wrap got=%0d want=1", u4_cnt); end
      aux_xact(16'hFFFF, 16'hFFFF, 5'h0F, lat);
      checks++; if (u16b_p !== 32'hFFFCFE00) begin failures++; $display("FAIL n16_t8_full got=%h want=FFFCFE00", u16b_p); end
      for (int i = 0; i < 4; i++) begin
         a = 16'($urandom_range(0, 65535));
         b = 16'($urandom_range(0, 65535));
         aux_xact(a, b, 5'h0F, lat);
         e16 = 32'(ref_p(16, 8, longint'(a), longint'(b), 5'h0F));
         checks++; if (u16b_p !== e16) begin failures++; $display("FAIL n16_t8 a=%h b=%h got=%h want=%h", a, b, u16b_p, e16); end
      end
   endtask

   initial begin
      test_reset();
      test_exact();
      test_approx();
      test_or_combine();
      test_back_to_back();
      test_reset_midstream();
      test_param_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
